mult_issue_ctrl: RTL and testbench
==================================

Name: mult_issue_ctrl

Overview:
- Issue/writeback controller directly upstream and downstream of the integer multiplier (`cv32e40p_mult`).
- Accepts decoded RV32M multiply requests (`funct3` 000–011) over a valid/ready handshake and translates `funct3` into operator and `short_signed` encoding.
- Holds operands stable on the multiplier inputs until its `ready` is seen, captures the result, and returns it with the destination register over a second valid/ready handshake.
- One request outstanding; a watchdog flags a multiplier that never completes.

Parameters:
- `TIMEOUT_CYCLES`, 15, maximum cycles in BUSY before the request is aborted with error (range 2–255).
- `RD_W`, 5, destination register tag width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous active-high reset. The multiplier's `rst_n` is driven as `~rst` at the parent.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when `req_valid_i & req_ready_o`.
- `req_funct3_i`  in  3  RV32M `funct3`.
- `req_op_a_i`  in  32  rs1 value.
- `req_op_b_i`  in  32  rs2 value.
- `req_rd_i`  in  `RD_W`  destination tag.
- `mult_enable_o`  out  1  multiplier `enable_i`.
- `mult_operator_o`  out  3  `MUL_MAC32`=3'b000, `MUL_H`=3'b110.
- `mult_short_signed_o`  out  2  11 mulh, 01 mulhsu, 00 mulhu / mul.
- `mult_op_a_o`  out  32  multiplier `op_a_i`.
- `mult_op_b_o`  out  32  multiplier `op_b_i`.
- `mult_ex_ready_o`  out  1  multiplier `ex_ready_i`.
- `mult_result_i`  in  32  multiplier `result_o`.
- `mult_ready_i`  in  1  multiplier `ready_o`.
- `wb_valid_o`  out  1  writeback valid.
- `wb_ready_i`  in  1  writeback consumer ready.
- `wb_rd_o`  out  `RD_W`  destination tag.
- `wb_data_o`  out  32  result; 0 when `wb_err_o`=1.
- `wb_err_o`  out  1  illegal `funct3` or timeout.

Behaviour:
- **Reset values (all outputs, checked in the cycle after `rst`=1):**
  - `mult_enable_o`=0, `wb_valid_o`=0, `wb_err_o`=0.
  - `wb_data_o`=0, `wb_rd_o`=0, `mult_operator_o`=000, `mult_short_signed_o`=00, `mult_op_a_o`/`mult_op_b_o`=0.
  - `mult_ex_ready_o`=0; `req_ready_o`=1 (state IDLE).
- **States:** IDLE, BUSY, WB (2-bit register).
- **`req_ready_o`** = (state==IDLE) | (state==WB & `wb_ready_i`). This gives back-to-back issue the same cycle a result drains.
- **Accept with legal `funct3`** (`funct3[2]`=0): register operands, rd and decoded controls → BUSY.
  - 000: operator `MUL_MAC32`, signed 00.
  - 001: operator `MUL_H`, signed 11.
  - 010: operator `MUL_H`, signed 01.
  - 011: operator `MUL_H`, signed 00.
- **Accept with illegal `funct3`** (1xx): no multiplier issue. Go directly to WB with `wb_err_o`=1, `wb_data_o`=0.
- **BUSY:**
  - `mult_enable_o`=1 and `mult_ex_ready_o`=1; operands and controls held constant.
  - Watchdog counter (8 bit) cleared on entry, increments each BUSY cycle.
  - Completion is sampled only when `mult_enable_o`=1. Idle-high `ready` before issue is never used.
  - `mult_ready_i`=1 → capture `mult_result_i` into `wb_data_o`, `wb_err_o`=0 → WB.
  - Counter reaches `TIMEOUT_CYCLES-1` without ready → `wb_data_o`=0, `wb_err_o`=1 → WB.
  - Ready wins if both occur in the same cycle.
- **Exit from BUSY:** `mult_enable_o` drops the cycle after the capture edge.
- **WB:**
  - `wb_valid_o`=1; data, rd and err held stable while `wb_ready_i`=0, for an unbounded stall.
  - `wb_ready_i`=1 → if a new request is accepted the same cycle, go to BUSY (or WB if illegal); else IDLE.
- **Latency, MUL:**
  - Accept edge at cycle 0; enable high in cycle 1; the single-cycle multiplier gives ready in cycle 1.
  - `wb_valid_o` in cycle 2.
- **Latency, MULH:** `wb_valid_o` one cycle after the multiplier's ready.
- **Data:** `wb_data_o` = `mult_result_i` bit-exact; no arithmetic in this block.
- **Reset mid-operation:** any state → IDLE next cycle. Any pending result or timeout is discarded, the counter is cleared, and `wb_valid_o` never pulses for the aborted request.
- **Input stability:** `req_*` inputs are ignored when not accepted. No combinational path from `req_*` to `mult_*`.

Test Plan:
- mul: `funct3`=000, a=7, b=0xFFFFFFFD, rd=5; multiplier model ready in cycle 1.
  - → `mult_operator_o`=000, `mult_short_signed_o`=00.
  - → `wb_valid_o` exactly 2 cycles after accept; `wb_data_o`=0xFFFFFFEB, `wb_rd_o`=5, `wb_err_o`=0.
- mulh / mulhsu / mulhu, multiplier ready after 5 BUSY cycles:
  - (001, 0x80000000, 0x80000000) → operator 110, signed 11, data 0x40000000.
  - (010, 0xFFFFFFFF, 0xFFFFFFFF) → signed 01, data 0xFFFFFFFF.
  - (011, 0xFFFFFFFF, 0xFFFFFFFF) → signed 00, data 0xFFFFFFFE.
  - Operands stable on `mult_op_*` throughout BUSY in all three cases.
- Illegal: `funct3`=100, rd=9 → `mult_enable_o` never asserted; next cycle `wb_valid_o`=1, `wb_err_o`=1, `wb_data_o`=0, `wb_rd_o`=9.
- Backpressure / back-to-back:
  - Hold `wb_ready_i`=0 for 10 cycles → `wb_*` stable, `req_ready_o`=0.
  - Then `wb_ready_i`=1 with a new request valid → accepted that cycle, `mult_enable_o`=1 next cycle.
- Timeout: `mult_ready_i` held 0 after issue → `wb_valid_o` with `wb_err_o`=1 after exactly 15 BUSY cycles; `mult_enable_o` low afterwards.
- Reset: assert `rst` for 1 cycle in BUSY (cycle 3 of a mulh) → all outputs at reset values next cycle, `req_ready_o`=1, no `wb_valid_o` pulse for the aborted request; following mul completes normally.

Source files
------------

// File: rtl/mult_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mult_issue_ctrl
//
// Issue/writeback controller that sits in front of and behind the RV32M integer
// multiplier. It accepts one decoded multiply request at a time, translates
// funct3 into the multiplier operator / short_signed controls, holds operands
// steady until the multiplier reports ready, captures the result and presents it
// with its destination tag on a writeback handshake. A watchdog turns a
// multiplier that never completes into an error writeback.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake
//   req_funct3_i          RV32M funct3 (000..011 legal, 1xx illegal)
//   req_op_a_i/op_b_i     rs1 / rs2 values
//   req_rd_i              destination register tag
//   mult_enable_o         multiplier enable (high only while BUSY)
//   mult_operator_o       MUL_MAC32 (000) or MUL_H (110)
//   mult_short_signed_o   operand signedness (bit0 = op_a, bit1 = op_b)
//   mult_op_a_o/op_b_o    registered operands driven to the multiplier
//   mult_ex_ready_o       multiplier ex_ready (high only while BUSY)
//   mult_result_i         multiplier result
//   mult_ready_i          multiplier ready (only honoured while BUSY)
//   wb_valid_o/ready_i    writeback handshake
//   wb_rd_o, wb_data_o    destination tag and result (data 0 on error)
//   wb_err_o              illegal funct3 or watchdog timeout
// -----------------------------------------------------------------------------
module mult_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned RD_W           = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_funct3_i,
  input  logic [31:0]     req_op_a_i,
  input  logic [31:0]     req_op_b_i,
  input  logic [RD_W-1:0] req_rd_i,
  output logic            mult_enable_o,
  output logic [2:0]      mult_operator_o,
  output logic [1:0]      mult_short_signed_o,
  output logic [31:0]     mult_op_a_o,
  output logic [31:0]     mult_op_b_o,
  output logic            mult_ex_ready_o,
  input  logic [31:0]     mult_result_i,
  input  logic            mult_ready_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [RD_W-1:0] wb_rd_o,
  output logic [31:0]     wb_data_o,
  output logic            wb_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WB   = 2'd2
  } state_e;

  localparam logic [2:0] MUL_MAC32 = 3'b000;
  localparam logic [2:0] MUL_H     = 3'b110;

  // Last BUSY cycle index before the watchdog fires: counter values
  // 0..TIMEOUT_CYCLES-1 give exactly TIMEOUT_CYCLES BUSY cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  logic [2:0]      operator_q, operator_d;
  logic [1:0]      short_signed_q, short_signed_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            accept;

  // Everything the multiplier sees comes from registers, so req_* never has a
  // combinational path to mult_*.
  assign mult_enable_o       = (state_q == S_BUSY);
  assign mult_ex_ready_o     = (state_q == S_BUSY);
  assign mult_operator_o     = operator_q;
  assign mult_short_signed_o = short_signed_q;
  assign mult_op_a_o         = op_a_q;
  assign mult_op_b_o         = op_b_q;
  assign wb_valid_o          = (state_q == S_WB);
  assign wb_rd_o             = rd_q;
  assign wb_data_o           = data_q;
  assign wb_err_o            = err_q;

  // Accepting while WB drains lets a new request issue in the same cycle the
  // previous result is consumed.
  assign req_ready_o = (state_q == S_IDLE) || ((state_q == S_WB) && wb_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    operator_d     = operator_q;
    short_signed_d = short_signed_q;
    rd_d           = rd_q;
    data_d         = data_q;
    err_d          = err_q;
    cnt_d          = cnt_q;

    case (state_q)
      S_BUSY: begin
        // Ready is checked before the watchdog so it wins a same-cycle tie.
        if (mult_ready_i) begin
          data_d  = mult_result_i;
          err_d   = 1'b0;
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        if (wb_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new request (only possible in IDLE or a draining WB) overrides the
    // state-specific next values above.
    if (accept) begin
      rd_d  = req_rd_i;
      cnt_d = '0;
      if (req_funct3_i[2]) begin
        // Illegal funct3: never touch the multiplier, report an error directly.
        data_d  = '0;
        err_d   = 1'b1;
        state_d = S_WB;
      end else begin
        op_a_d  = req_op_a_i;
        op_b_d  = req_op_b_i;
        state_d = S_BUSY;
        case (req_funct3_i[1:0])
          2'b00:   begin operator_d = MUL_MAC32; short_signed_d = 2'b00; end
          2'b01:   begin operator_d = MUL_H;     short_signed_d = 2'b11; end
          2'b10:   begin operator_d = MUL_H;     short_signed_d = 2'b01; end
          default: begin operator_d = MUL_H;     short_signed_d = 2'b00; end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q        <= S_IDLE;
      op_a_q         <= '0;
      op_b_q         <= '0;
      operator_q     <= MUL_MAC32;
      short_signed_q <= 2'b00;
      rd_q           <= '0;
      data_q         <= '0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      operator_q     <= operator_d;
      short_signed_q <= short_signed_d;
      rd_q           <= rd_d;
      data_q         <= data_d;
      err_q          <= err_d;
      cnt_q          <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_issue_ctrl
//
// Self-checking bench for mult_issue_ctrl. A behavioural multiplier answers the
// DUT after a per-request number of enabled cycles (0 = never). Expected results
// come from the RV32M definition of each funct3, evaluated with 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_mult_issue_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_op_a_i;
  logic [31:0] req_op_b_i;
  logic [4:0]  req_rd_i;
  logic        mult_enable_o;
  logic [2:0]  mult_operator_o;
  logic [1:0]  mult_short_signed_o;
  logic [31:0] mult_op_a_o;
  logic [31:0] mult_op_b_o;
  logic        mult_ex_ready_o;
  logic [31:0] mult_result_i;
  logic        mult_ready_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_err_o;

  int n_vec = 0;
  int n_err = 0;

  mult_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .RD_W(5)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_funct3_i        (req_funct3_i),
    .req_op_a_i          (req_op_a_i),
    .req_op_b_i          (req_op_b_i),
    .req_rd_i            (req_rd_i),
    .mult_enable_o       (mult_enable_o),
    .mult_operator_o     (mult_operator_o),
    .mult_short_signed_o (mult_short_signed_o),
    .mult_op_a_o         (mult_op_a_o),
    .mult_op_b_o         (mult_op_b_o),
    .mult_ex_ready_o     (mult_ex_ready_o),
    .mult_result_i       (mult_result_i),
    .mult_ready_i        (mult_ready_i),
    .wb_valid_o          (wb_valid_o),
    .wb_ready_i          (wb_ready_i),
    .wb_rd_o             (wb_rd_o),
    .wb_data_o           (wb_data_o),
    .wb_err_o            (wb_err_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural multiplier ----------------
  int unsigned mdl_delay = 1;
  int unsigned en_cnt    = 0;

  function automatic logic [31:0] mult_model(input logic [2:0] op, input logic [1:0] ss,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = {{32{ss[0] & a[31]}}, a};
    xb = {{32{ss[1] & b[31]}}, b};
    p  = xa * xb;
    if (op == 3'b000) return p[31:0];
    if (op == 3'b110) return p[63:32];
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) en_cnt <= mult_enable_o ? en_cnt + 1 : 0;

  // Ready idles high while not enabled, as the real multiplier does.
  assign mult_ready_i  = mult_enable_o ? (mdl_delay != 0 && en_cnt == mdl_delay - 1) : 1'b1;
  assign mult_result_i = mult_model(mult_operator_o, mult_short_signed_o, mult_op_a_o, mult_op_b_o);

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'b000:  begin p = 64'(sa * sb); return p[31:0];  end
      3'b001:  begin p = 64'(sa * sb); return p[63:32]; end
      3'b010:  begin p = 64'(sa * ub); return p[63:32]; end
      default: begin p = 64'(ua * ub); return p[63:32]; end
    endcase
  endfunction

  typedef struct {
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          delay;
    int          stall;
    bit          drain;
    logic [2:0]  exp_op;
    logic [1:0]  exp_ss;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  function automatic vec_t make_vec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] rd, input int delay, input int stall,
                                    input bit drain);
    vec_t v;
    bit   timeout;
    v.funct3 = f; v.a = a; v.b = b; v.rd = rd;
    v.delay = delay; v.stall = stall; v.drain = drain;
    v.exp_op = (f[1:0] == 2'b00) ? 3'b000 : 3'b110;
    v.exp_ss = (f[1:0] == 2'b01) ? 2'b11 : (f[1:0] == 2'b10) ? 2'b01 : 2'b00;
    timeout  = (delay == 0) || (delay > TIMEOUT);
    if (f[2]) begin
      v.exp_err = 1'b1; v.exp_data = '0; v.exp_lat = 1;
    end else if (timeout) begin
      v.exp_err = 1'b1; v.exp_data = '0; v.exp_lat = TIMEOUT + 1;
    end else begin
      v.exp_err = 1'b0; v.exp_data = ref_result(f, a, b); v.exp_lat = delay + 1;
    end
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_enable",   mult_enable_o,       0);
    check("rst_wb_valid", wb_valid_o,          0);
    check("rst_wb_err",   wb_err_o,            0);
    check("rst_wb_data",  wb_data_o,           0);
    check("rst_wb_rd",    wb_rd_o,             0);
    check("rst_operator", mult_operator_o,     0);
    check("rst_ss",       mult_short_signed_o, 0);
    check("rst_op_a",     mult_op_a_o,         0);
    check("rst_op_b",     mult_op_b_o,         0);
    check("rst_ex_ready", mult_ex_ready_o,     0);
    check("rst_req_ready", req_ready_o,        1);
  endtask

  // Issue one request and follow it to writeback. from_wb: the previous result
  // is still pending and is drained in the same cycle this request is accepted.
  task automatic run_req(input vec_t v, input bit from_wb);
    int lat;
    int guard;
    mdl_delay    = v.delay;
    req_valid_i  = 1'b1;
    req_funct3_i = v.funct3;
    req_op_a_i   = v.a;
    req_op_b_i   = v.b;
    req_rd_i     = v.rd;
    wb_ready_i   = from_wb;
    #1;
    guard = 0;
    while (!req_ready_o && guard < 50) begin
      tick();
      guard++;
    end
    check("req_ready", req_ready_o, 1);
    tick();  // accept edge
    req_valid_i  = 1'b0;
    wb_ready_i   = 1'b0;
    req_funct3_i = 3'($urandom);
    req_op_a_i   = $urandom;
    req_op_b_i   = $urandom;
    req_rd_i     = 5'($urandom);
    lat = 1;
    while (!wb_valid_o && lat < 64) begin
      if (!v.funct3[2]) begin
        check("busy_enable",   mult_enable_o,       1);
        check("busy_ex_ready", mult_ex_ready_o,     1);
        check("busy_operator", mult_operator_o,     v.exp_op);
        check("busy_ss",       mult_short_signed_o, v.exp_ss);
        check("busy_op_a",     mult_op_a_o,         v.a);
        check("busy_op_b",     mult_op_b_o,         v.b);
      end else begin
        check("illegal_no_issue", mult_enable_o, 0);
      end
      tick();
      lat++;
    end
    check("wb_latency",   lat,           v.exp_lat);
    check("wb_valid",     wb_valid_o,    1);
    check("wb_data",      wb_data_o,     v.exp_data);
    check("wb_err",       wb_err_o,      v.exp_err);
    check("wb_rd",        wb_rd_o,       v.rd);
    check("wb_enable_lo", mult_enable_o, 0);
    for (int i = 0; i < v.stall; i++) begin
      tick();
      check("stall_valid",     wb_valid_o,  1);
      check("stall_data",      wb_data_o,   v.exp_data);
      check("stall_err",       wb_err_o,    v.exp_err);
      check("stall_rd",        wb_rd_o,     v.rd);
      check("stall_req_ready", req_ready_o, 0);
    end
    if (v.drain) begin
      wb_ready_i = 1'b1;
      tick();
      wb_ready_i = 1'b0;
      #1;
      check("drain_valid",     wb_valid_o,  0);
      check("drain_req_ready", req_ready_o, 1);
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[8];
  bit   pending;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst          = 1'b1;
    req_valid_i  = 1'b0;
    req_funct3_i = '0;
    req_op_a_i   = '0;
    req_op_b_i   = '0;
    req_rd_i     = '0;
    wb_ready_i   = 1'b0;

    //               funct3  a             b             rd  dly stall drain
    tbl[0] = make_vec(3'b000, 32'd7,        32'hFFFFFFFD, 5,  1,  3,  1);
    tbl[1] = make_vec(3'b001, 32'h80000000, 32'h80000000, 1,  5,  0,  1);
    tbl[2] = make_vec(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  5,  0,  1);
    tbl[3] = make_vec(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 3,  5,  10, 0);
    tbl[4] = make_vec(3'b000, 32'h1234,     32'h10,       4,  1,  0,  1);
    tbl[5] = make_vec(3'b100, 32'h1,        32'h2,        9,  1,  2,  1);
    tbl[6] = make_vec(3'b000, 32'd3,        32'd4,        7,  0,  0,  1);
    tbl[7] = make_vec(3'b011, 32'hFFFFFFFF, 32'd2,        31, 15, 0,  1);

    tick();
    tick();
    check_reset_vals();
    rst = 1'b0;
    tick();

    // Spec-derived table; tbl[3] stalls 10 cycles and tbl[4] issues back-to-back.
    pending = 1'b0;
    foreach (tbl[i]) begin
      run_req(tbl[i], pending);
      pending = !tbl[i].drain;
    end

    // Reset in cycle 3 of a mulh: aborted request never writes back.
    mdl_delay    = 5;
    req_valid_i  = 1'b1;
    req_funct3_i = 3'b001;
    req_op_a_i   = 32'h55;
    req_op_b_i   = 32'h66;
    req_rd_i     = 5'd12;
    tick();
    req_valid_i = 1'b0;
    check("pre_rst_enable", mult_enable_o, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_no_wb", wb_valid_o, 0);
    end
    run_req(make_vec(3'b000, 32'd6, 32'd9, 5'd13, 1, 0, 1), 1'b0);

    // Randomised requests against the reference model.
    pending = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      int         dly;
      vec_t       v;
      f   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16));
      v   = make_vec(f, $urandom, $urandom, 5'($urandom), dly,
                     int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      run_req(v, pending);
      pending = !v.drain;
    end
    if (pending) begin
      wb_ready_i = 1'b1;
      tick();
      wb_ready_i = 1'b0;
      #1;
      check("final_drain", wb_valid_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
